// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32I pipeline hazard/forwarding logic:
// forward-select encodings, the shadow-pipeline entry and the stall FSM states.
package pipe_pkg;

    localparam int RV_REG_ADDR_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic                     valid;
        logic [RV_REG_ADDR_W-1:0] rd;
        logic                     regwrite;
        logic                     memread;
    } shadow_entry_t;

    typedef enum logic {
        RUN,
        STALL1
    } hz_state_t;

    // x0 is hard-wired to zero, so an entry targeting it never produces a value
    function automatic logic is_writer(input shadow_entry_t e);
        return e.valid && e.regwrite && (e.rd != '0);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding select: picks the youngest in-flight producer of rs.
// WB is never a source because the register file writes through.
module fwd_select
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = RV_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  uses,
    input  shadow_entry_t         ex_entry,
    input  shadow_entry_t         mem_entry,
    output logic [1:0]            sel
);

    // A load still in EX has no data yet; that case is handled by the stall
    always_comb begin
        sel = FWD_RF;
        if (uses) begin
            if (is_writer(ex_entry) && !ex_entry.memread && (ex_entry.rd == rs)) begin
                sel = FWD_MEM;
            end else if (is_writer(mem_entry) && (mem_entry.rd == rs)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline: shadow
// pipeline of destination registers, registered ALU forward selects, load-use stall and flush.
module hazard_fwd_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = RV_REG_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  ex_branch_taken,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall,
    output logic                  bubble,
    output logic                  flush,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    shadow_entry_t ex_entry, mem_entry, wb_entry, id_entry;
    hz_state_t     state, state_next;
    logic          load_use;
    logic          advance;
    logic [1:0]    sel_a, sel_b;

    assign id_entry = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread};

    assign load_use = id_valid && is_writer(ex_entry) && ex_entry.memread &&
                      ((id_uses_rs1 && (id_rs1 == ex_entry.rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_entry.rd)));

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_sel_a (
        .rs        (id_rs1),
        .uses      (id_uses_rs1),
        .ex_entry  (ex_entry),
        .mem_entry (mem_entry),
        .sel       (sel_a)
    );

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_sel_b (
        .rs        (id_rs2),
        .uses      (id_uses_rs2),
        .ex_entry  (ex_entry),
        .mem_entry (mem_entry),
        .sel       (sel_b)
    );

    // A taken branch squashes the ID instruction, so it overrides any load-use stall
    always_comb begin
        flush      = ex_branch_taken && !rst;
        stall      = 1'b0;
        bubble     = flush;
        state_next = state;
        if (flush) begin
            state_next = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (load_use) begin
                        stall      = 1'b1;
                        bubble     = 1'b1;
                        state_next = STALL1;
                    end
                end
                STALL1:  state_next = RUN;
                default: state_next = RUN;
            endcase
        end
    end

    assign advance = id_valid && !bubble;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // The shadow pipeline never freezes; a stall just injects an empty EX entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_entry  <= '0;
            mem_entry <= '0;
            wb_entry  <= '0;
        end else begin
            ex_entry  <= advance ? id_entry : '0;
            mem_entry <= ex_entry;
            wb_entry  <= mem_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else begin
            fwd_a_sel <= advance ? sel_a : FWD_RF;
            fwd_b_sel <= advance ? sel_b : FWD_RF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, stall};
            flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, flush};
        end
    end

endmodule
